// File: rtl/vga_pattern_gen_pkg.sv
// Shared types, colour constants and the per-axis bounce rule for the VGA pattern stage.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_NOISE = 2'd3
    } mode_t;

    // RGB332 packed as {R[2:0], G[2:0], B[1:0]}
    localparam logic [7:0] BLACK   = 8'h00;
    localparam logic [7:0] WHITE   = 8'hFF;
    localparam logic [7:0] YELLOW  = 8'hFC;
    localparam logic [7:0] DIMBLUE = 8'h01;

    typedef struct packed {
        logic        dir;   // 1 = moving towards larger coordinates
        logic [12:0] pos;
    } axis_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       chk;
        logic       hit;
        logic       rnd;
        logic       hs;
        logic       vs;
    } stage1_t;

    // Clamp at the limits instead of wrapping; direction flips only once the step would overshoot.
    function automatic axis_t bounce(input axis_t cur, input logic [12:0] lim, input logic [12:0] step);
        axis_t       res;
        logic [13:0] nxt;
        res = cur;
        nxt = {1'b0, cur.pos} + {1'b0, step};
        if (cur.dir) begin
            if (nxt > {1'b0, lim}) begin
                res.pos = lim;
                res.dir = 1'b0;
            end else begin
                res.pos = nxt[12:0];
            end
        end else begin
            if (cur.pos < step) begin
                res.pos = '0;
                res.dir = 1'b1;
            end else begin
                res.pos = cur.pos - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between vga_sync/test logic (master) and the pattern stage (slave).
interface vga_pattern_gen_if;
    logic [12:0] locX;
    logic [12:0] locY;
    logic        in_image;
    logic        sync_h_in;
    logic        sync_v_in;
    logic [1:0]  mode;
    logic        rnd_bit;
    logic [2:0]  vgaRed;
    logic [2:0]  vgaGreen;
    logic [1:0]  vgaBlue;
    logic        Hsync;
    logic        Vsync;
    logic        frame_tick;

    modport master (
        output locX, locY, in_image, sync_h_in, sync_v_in, mode, rnd_bit,
        input  vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_tick
    );

    modport slave (
        input  locX, locY, in_image, sync_h_in, sync_v_in, mode, rnd_bit,
        output vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_tick
    );
endinterface

// File: rtl/vga_pattern_gen_box_mover.sv
// Bouncing-box position and direction for both axes, advanced once per frame start.
module vga_box_mover
    import vga_pattern_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2
) (
    input  logic        PIXEL_CLK,
    input  logic        RST_IN,
    input  logic        step_en,
    output logic [12:0] box_x,
    output logic [12:0] box_y
);

    localparam logic [12:0] LIM_X  = 13'(H_ACTIVE - BOX_SIZE);
    localparam logic [12:0] LIM_Y  = 13'(V_ACTIVE - BOX_SIZE);
    localparam logic [12:0] STEP_W = 13'(STEP);
    localparam axis_t       AXIS_RESET = '{dir: 1'b1, pos: 13'd0};

    axis_t x_q;
    axis_t y_q;

    always_ff @(posedge PIXEL_CLK or posedge RST_IN) begin
        if (RST_IN) begin
            x_q <= AXIS_RESET;
            y_q <= AXIS_RESET;
        end else if (step_en) begin
            x_q <= bounce(x_q, LIM_X, STEP_W);
            y_q <= bounce(y_q, LIM_Y, STEP_W);
        end
    end

    assign box_x = x_q.pos;
    assign box_y = y_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage: frame-start detect, mode latch, 2-stage colour pipeline, sync re-alignment.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned BOX_SIZE        = 32,
    parameter int unsigned STEP            = 2,
    parameter int unsigned BAR_SHIFT       = 6,
    parameter int unsigned CHK_SHIFT       = 4,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              PIXEL_CLK,
    input  logic              RST_IN,
    vga_pattern_gen_if.slave  vga
);

    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic        v_d;
    logic        frame_start;
    mode_t       mode_q;
    logic [7:0]  frame_cnt;
    logic [12:0] box_x;
    logic [12:0] box_y;
    stage1_t     s1_d;
    stage1_t     s1_q;
    logic [7:0]  colour;
    logic [7:0]  rgb_q;
    logic        hs_q;
    logic        vs_q;

    // XOR with the idle level turns either polarity into an active-high flag
    assign frame_start    = (vga.sync_v_in ^ SYNC_IDLE) & ~(v_d ^ SYNC_IDLE);
    assign vga.frame_tick = frame_start & ~RST_IN;

    always_ff @(posedge PIXEL_CLK or posedge RST_IN) begin
        if (RST_IN) begin
            v_d       <= SYNC_IDLE;
            mode_q    <= MODE_BARS;
            frame_cnt <= '0;
        end else begin
            v_d <= vga.sync_v_in;
            if (frame_start) begin
                mode_q    <= mode_t'(vga.mode);
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box_mover (
        .PIXEL_CLK (PIXEL_CLK),
        .RST_IN    (RST_IN),
        .step_en   (frame_start),
        .box_x     (box_x),
        .box_y     (box_y)
    );

    always_comb begin
        logic [12:0] chk_sum;
        logic        hit_x;
        logic        hit_y;
        chk_sum = vga.locX + {5'd0, frame_cnt};
        hit_x   = ({1'b0, box_x} <= {1'b0, vga.locX}) &&
                  ({1'b0, vga.locX} < ({1'b0, box_x} + 14'(BOX_SIZE)));
        hit_y   = ({1'b0, box_y} <= {1'b0, vga.locY}) &&
                  ({1'b0, vga.locY} < ({1'b0, box_y} + 14'(BOX_SIZE)));
        s1_d       = '0;
        s1_d.valid = vga.in_image;
        s1_d.idx   = vga.locX[BAR_SHIFT +: 3];
        s1_d.chk   = chk_sum[CHK_SHIFT] ^ vga.locY[CHK_SHIFT];
        s1_d.hit   = hit_x & hit_y;
        s1_d.rnd   = vga.rnd_bit;
        s1_d.hs    = vga.sync_h_in;
        s1_d.vs    = vga.sync_v_in;
    end

    always_ff @(posedge PIXEL_CLK or posedge RST_IN) begin
        if (RST_IN) begin
            s1_q    <= '0;
            s1_q.hs <= SYNC_IDLE;
            s1_q.vs <= SYNC_IDLE;
        end else begin
            s1_q <= s1_d;
        end
    end

    always_comb begin
        colour = BLACK;
        if (s1_q.valid) begin
            case (mode_q)
                MODE_BARS:  colour = {{3{s1_q.idx[2]}}, {3{s1_q.idx[1]}}, {2{s1_q.idx[0]}}};
                MODE_CHECK: colour = s1_q.chk ? WHITE : BLACK;
                MODE_BOX:   colour = s1_q.hit ? YELLOW : DIMBLUE;
                MODE_NOISE: colour = {{3{s1_q.rnd}}, {3{s1_q.rnd}}, {2{s1_q.rnd}}};
                default:    colour = BLACK;
            endcase
        end
    end

    always_ff @(posedge PIXEL_CLK or posedge RST_IN) begin
        if (RST_IN) begin
            rgb_q <= BLACK;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
        end else begin
            rgb_q <= colour;
            hs_q  <= s1_q.hs;
            vs_q  <= s1_q.vs;
        end
    end

    assign vga.vgaRed   = rgb_q[7:5];
    assign vga.vgaGreen = rgb_q[4:2];
    assign vga.vgaBlue  = rgb_q[1:0];
    assign vga.Hsync    = hs_q;
    assign vga.Vsync    = vs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: bars, checker scroll, noise, box bounce, mode latch, async reset.
module tb_vga_pattern_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vga_pattern_gen_if bus ();

    vga_pattern_gen dut (
        .PIXEL_CLK (clk),
        .RST_IN    (rst),
        .vga       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_pixel(input logic [12:0] x, input logic [12:0] y, input logic img,
                               output logic [7:0] rgb);
        bus.locX     = x;
        bus.locY     = y;
        bus.in_image = img;
        tick();
        tick();
        rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
    endtask

    task automatic frame_pulse;
        bus.sync_v_in = 1'b0;
        tick();
        bus.sync_v_in = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        logic [7:0] rgb;
        rst           = 1'b1;
        bus.locX      = 13'h80;
        bus.locY      = '0;
        bus.in_image  = 1'b1;
        bus.sync_h_in = 1'b0;
        bus.sync_v_in = 1'b0;
        bus.mode      = 2'd0;
        bus.rnd_bit   = 1'b1;
        tick();
        tick();
        rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h expected %h", rgb, 8'h00); end
        checks++;
        if (bus.Hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", bus.Hsync); end
        checks++;
        if (bus.Vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", bus.Vsync); end
        checks++;
        if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.frame_tick); end
        bus.sync_v_in = 1'b1;
        bus.sync_h_in = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bars;
        logic [7:0] rgb;
        logic       pat [10];
        apply_pixel(13'h080, 13'd5, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h1C) begin errors++; $display("FAIL bars_idx2: got %h expected %h", rgb, 8'h1C); end
        apply_pixel(13'h040, 13'd5, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h03) begin errors++; $display("FAIL bars_idx1: got %h expected %h", rgb, 8'h03); end
        apply_pixel(13'h1C0, 13'd5, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL bars_idx7: got %h expected %h", rgb, 8'hFF); end
        apply_pixel(13'h200, 13'd5, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL bars_wrap: got %h expected %h", rgb, 8'h00); end
        apply_pixel(13'h1C0, 13'd5, 1'b0, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL bars_blank: got %h expected %h", rgb, 8'h00); end
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                checks++;
                if (bus.Hsync !== pat[i-2]) begin
                    errors++;
                    $display("FAIL hsync_delay[%0d]: got %b expected %b", i, bus.Hsync, pat[i-2]);
                end
            end
            bus.sync_h_in = pat[i];
            tick();
        end
        bus.sync_h_in = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.Vsync !== 1'b1) begin errors++; $display("FAIL vsync_idle: got %b expected 1", bus.Vsync); end
    endtask

    task automatic test_mode_switch;
        logic [7:0] rgb;
        bus.mode = 2'd1;
        apply_pixel(13'h080, 13'd0, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h1C) begin errors++; $display("FAIL mode_hold_bars: got %h expected %h", rgb, 8'h1C); end
        bus.sync_v_in = 1'b0;
        #1;
        checks++;
        if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL tick_high: got %b expected 1", bus.frame_tick); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle: got %b expected 0", bus.frame_tick); end
        tick();
        checks++;
        if (bus.Vsync !== 1'b0) begin errors++; $display("FAIL vsync_delay_low: got %b expected 0", bus.Vsync); end
        bus.sync_v_in = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.Vsync !== 1'b1) begin errors++; $display("FAIL vsync_delay_high: got %b expected 1", bus.Vsync); end
        apply_pixel(13'h00F, 13'h000, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL chk_f1_white: got %h expected %h", rgb, 8'hFF); end
        apply_pixel(13'h00E, 13'h000, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL chk_f1_black: got %h expected %h", rgb, 8'h00); end
        apply_pixel(13'h00E, 13'h010, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL chk_f1_row: got %h expected %h", rgb, 8'hFF); end
    endtask

    task automatic test_checker_scroll;
        logic [7:0] rgb;
        frame_pulse();
        apply_pixel(13'h00E, 13'h000, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL chk_f2_scroll: got %h expected %h", rgb, 8'hFF); end
        apply_pixel(13'h00D, 13'h000, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL chk_f2_black: got %h expected %h", rgb, 8'h00); end
        apply_pixel(13'h00E, 13'h000, 1'b0, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL chk_blank: got %h expected %h", rgb, 8'h00); end
    endtask

    task automatic test_noise;
        logic [7:0] rgb;
        bus.mode = 2'd3;
        frame_pulse();
        bus.rnd_bit = 1'b1;
        apply_pixel(13'd100, 13'd100, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL noise_one: got %h expected %h", rgb, 8'hFF); end
        bus.rnd_bit = 1'b0;
        apply_pixel(13'd100, 13'd100, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL noise_zero: got %h expected %h", rgb, 8'h00); end
        bus.rnd_bit = 1'b1;
        apply_pixel(13'd100, 13'd100, 1'b0, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL noise_blank: got %h expected %h", rgb, 8'h00); end
    endtask

    task automatic test_box;
        logic [7:0] rgb;
        bus.mode = 2'd2;
        frame_pulse();                       // frame 4: box at (8,8)
        apply_pixel(13'd8, 13'd8, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f4_corner: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd7, 13'd8, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f4_left: got %h expected %h", rgb, 8'h01); end
        apply_pixel(13'd39, 13'd39, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f4_far: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd40, 13'd8, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f4_right: got %h expected %h", rgb, 8'h01); end
        apply_pixel(13'd8, 13'd40, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f4_below: got %h expected %h", rgb, 8'h01); end
        apply_pixel(13'd8, 13'd8, 1'b0, rgb);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL box_blank: got %h expected %h", rgb, 8'h00); end
    endtask

    task automatic test_box_bounce;
        logic [7:0] rgb;
        for (int n = 5; n <= 303; n++) frame_pulse();
        apply_pixel(13'd606, 13'd292, 1'b1, rgb);   // x=606 y=292
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f303_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd605, 13'd292, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f303_out: got %h expected %h", rgb, 8'h01); end
        frame_pulse();                              // x=608 (limit, still +) y=290
        apply_pixel(13'd608, 13'd290, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f304_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd607, 13'd290, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f304_out: got %h expected %h", rgb, 8'h01); end
        apply_pixel(13'd639, 13'd290, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f304_edge: got %h expected %h", rgb, 8'hFC); end
        frame_pulse();                              // overshoot: clamp 608, turn; y=288
        apply_pixel(13'd608, 13'd288, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f305_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd607, 13'd288, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f305_out: got %h expected %h", rgb, 8'h01); end
        frame_pulse();                              // x=606 y=286
        apply_pixel(13'd606, 13'd286, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f306_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd605, 13'd286, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f306_out: got %h expected %h", rgb, 8'h01); end
        for (int n = 307; n <= 449; n++) frame_pulse();
        apply_pixel(13'd320, 13'd0, 1'b1, rgb);     // x=320 y=0
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f449_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd320, 13'd32, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f449_below: got %h expected %h", rgb, 8'h01); end
        apply_pixel(13'd319, 13'd0, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f449_left: got %h expected %h", rgb, 8'h01); end
        frame_pulse();                              // y clamps at 0 and turns; x=318
        apply_pixel(13'd318, 13'd0, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f450_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd317, 13'd0, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f450_left: got %h expected %h", rgb, 8'h01); end
        frame_pulse();                              // x=316 y=2
        apply_pixel(13'd316, 13'd2, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL box_f451_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd316, 13'd1, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL box_f451_above: got %h expected %h", rgb, 8'h01); end
    endtask

    task automatic test_async_reset;
        logic [7:0] rgb;
        bus.sync_h_in = 1'b0;
        apply_pixel(13'd316, 13'd2, 1'b1, rgb);
        checks++;
        if (bus.Hsync !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync: got %b expected 0", bus.Hsync); end
        #2;
        rst = 1'b1;
        #1;
        rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL async_rst_rgb: got %h expected %h", rgb, 8'h00); end
        checks++;
        if (bus.Hsync !== 1'b1) begin errors++; $display("FAIL async_rst_hsync: got %b expected 1", bus.Hsync); end
        bus.locX     = 13'h080;
        bus.locY     = 13'd0;
        bus.in_image = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL resume_lat1: got %h expected %h", rgb, 8'h00); end
        checks++;
        if (bus.Hsync !== 1'b1) begin errors++; $display("FAIL resume_hsync1: got %b expected 1", bus.Hsync); end
        tick();
        rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
        checks++;
        if (rgb !== 8'h1C) begin errors++; $display("FAIL resume_bars: got %h expected %h", rgb, 8'h1C); end
        checks++;
        if (bus.Hsync !== 1'b0) begin errors++; $display("FAIL resume_hsync2: got %b expected 0", bus.Hsync); end
        frame_pulse();                              // mode 2 adopted, box restarts: (2,2)
        apply_pixel(13'd2, 13'd2, 1'b1, rgb);
        checks++;
        if (rgb !== 8'hFC) begin errors++; $display("FAIL post_rst_box_in: got %h expected %h", rgb, 8'hFC); end
        apply_pixel(13'd1, 13'd2, 1'b1, rgb);
        checks++;
        if (rgb !== 8'h01) begin errors++; $display("FAIL post_rst_box_out: got %h expected %h", rgb, 8'h01); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bars();
        test_mode_switch();
        test_checker_scroll();
        test_noise();
        test_box();
        test_box_bounce();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
